// File: rtl/round_key_bank.sv
// round_key_bank: multi-slot AES round-key store, replayed forward or reverse on a valid/ready stream.
// Optional macro RKB_EQINV_EN: reverse replay passes middle keys through InvMixColumns.
module round_key_bank #(
  parameter int unsigned NUM_SLOTS = 2,
  parameter int unsigned MAX_RK    = 15,
  parameter int unsigned RK_W      = 128,
  localparam int unsigned SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [SLOT_W-1:0]    load_slot,
  input  logic [1:0]           load_key_length,
  input  logic                 load_rk_valid,
  input  logic [RK_W-1:0]      load_rk,
  output logic                 load_busy,
  output logic                 load_done,
  input  logic                 rd_start,
  input  logic [SLOT_W-1:0]    rd_slot,
  input  logic                 rd_decrypt,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [RK_W-1:0]      rk_data,
  output logic                 rk_last,
  output logic                 rd_busy,
  output logic [NUM_SLOTS-1:0] slot_ready,
  output logic                 err
);

  localparam int unsigned IDX_W = (MAX_RK > 1) ? $clog2(MAX_RK) : 1;
  localparam int unsigned DEPTH = NUM_SLOTS * MAX_RK;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic LD_IDLE   = 1'b0;
  localparam logic LD_FILL   = 1'b1;
  localparam logic RD_IDLE   = 1'b0;
  localparam logic RD_STREAM = 1'b1;

  logic [RK_W-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]  slot_nr [NUM_SLOTS];

  logic              ld_state, ld_state_nx_c;
  logic [SLOT_W-1:0] ld_slot;
  logic [IDX_W-1:0]  ld_idx, ld_nr, ld_len_nr_c;
  logic              ld_accept_c, ld_err_c, ld_write_c, ld_done_c, ld_legal_c;
  logic [AW-1:0]     ld_addr_c;

  logic              rd_state, rd_state_nx_c;
  logic [SLOT_W-1:0] rd_slot_q, rd_slot_c;
  logic              rd_dir, rd_dir_c;
  logic [IDX_W-1:0]  rd_idx, rd_idx_nx_c, rd_nr, rd_nr_c;
  logic              rd_err_c, rd_fetch_c, rd_ok_c, rd_last_nx_c;
  logic [AW-1:0]     rd_addr_c;
  logic [RK_W-1:0]   rd_word_c;

  function automatic logic [AW-1:0] addr_of(input logic [SLOT_W-1:0] s, input logic [IDX_W-1:0] i);
    return AW'(32'(s) * MAX_RK + 32'(i));
  endfunction

`ifdef RKB_EQINV_EN
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column-major state, byte 0 in the MSBs; coefficients 0e/0b/0d/09 built from xtime chains
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   x2 [4];
    logic [7:0]   x4 [4];
    logic [7:0]   x8 [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        a[i]  = s[127 - 32*c - 8*i -: 8];
        x2[i] = xtime(a[i]);
        x4[i] = xtime(x2[i]);
        x8[i] = xtime(x4[i]);
      end
      for (int i = 0; i < 4; i++) begin
        r[127 - 32*c - 8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                                 ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                                 ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                                 ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      end
    end
    return r;
  endfunction
`endif

  // Load FSM next state: capture Nr+1 beats into the target slot
  always_comb begin
    ld_state_nx_c = ld_state;
    ld_accept_c   = 1'b0;
    ld_err_c      = 1'b0;
    ld_write_c    = 1'b0;
    ld_done_c     = 1'b0;
    case (load_key_length)
      2'b00:   ld_len_nr_c = IDX_W'(10);
      2'b01:   ld_len_nr_c = IDX_W'(12);
      default: ld_len_nr_c = IDX_W'(14);
    endcase
    ld_legal_c = (load_key_length != 2'b11) && (32'(load_slot) < NUM_SLOTS) &&
                 !((rd_state == RD_STREAM) && (rd_slot_q == load_slot));
    case (ld_state)
      LD_IDLE: begin
        if (load_start) begin
          if (ld_legal_c) begin
            ld_accept_c   = 1'b1;
            ld_state_nx_c = LD_FILL;
          end else begin
            ld_err_c = 1'b1;
          end
        end
      end
      LD_FILL: begin
        ld_err_c = load_start;
        if (load_rk_valid) begin
          ld_write_c = 1'b1;
          if (ld_idx == ld_nr) begin
            ld_done_c     = 1'b1;
            ld_state_nx_c = LD_IDLE;
          end
        end
      end
      default: ld_state_nx_c = LD_IDLE;
    endcase
  end

  assign ld_addr_c = addr_of(ld_slot, ld_idx);

  // Read FSM next state; a same-cycle load of the same slot takes priority
  always_comb begin
    rd_state_nx_c = rd_state;
    rd_err_c      = 1'b0;
    rd_fetch_c    = 1'b0;
    rd_slot_c     = rd_slot_q;
    rd_dir_c      = rd_dir;
    rd_nr_c       = rd_nr;
    rd_idx_nx_c   = rd_idx;
    rd_ok_c = (32'(rd_slot) < NUM_SLOTS) && slot_ready[rd_slot] &&
              !(ld_accept_c && (load_slot == rd_slot));
    case (rd_state)
      RD_IDLE: begin
        if (rd_start) begin
          if (rd_ok_c) begin
            rd_fetch_c    = 1'b1;
            rd_state_nx_c = RD_STREAM;
            rd_slot_c     = rd_slot;
            rd_dir_c      = rd_decrypt;
            rd_nr_c       = slot_nr[rd_slot];
            rd_idx_nx_c   = rd_decrypt ? slot_nr[rd_slot] : '0;
          end else begin
            rd_err_c = 1'b1;
          end
        end
      end
      RD_STREAM: begin
        rd_err_c = rd_start;
        if (rk_valid && rk_ready) begin
          if (rk_last) begin
            rd_state_nx_c = RD_IDLE;
          end else begin
            rd_fetch_c  = 1'b1;
            rd_idx_nx_c = rd_dir ? rd_idx - IDX_W'(1) : rd_idx + IDX_W'(1);
          end
        end
      end
      default: rd_state_nx_c = RD_IDLE;
    endcase
    rd_last_nx_c = rd_dir_c ? (rd_idx_nx_c == '0) : (rd_idx_nx_c == rd_nr_c);
  end

  assign rd_addr_c = addr_of(rd_slot_c, rd_idx_nx_c);

  always_comb begin
    rd_word_c = mem[rd_addr_c];
`ifdef RKB_EQINV_EN
    if (rd_dir_c && (rd_idx_nx_c != '0) && (rd_idx_nx_c != rd_nr_c))
      rd_word_c = RK_W'(inv_mix_columns(128'(mem[rd_addr_c])));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state   <= LD_IDLE;
      ld_slot    <= '0;
      ld_idx     <= '0;
      ld_nr      <= '0;
      rd_state   <= RD_IDLE;
      rd_slot_q  <= '0;
      rd_dir     <= 1'b0;
      rd_idx     <= '0;
      rd_nr      <= '0;
      slot_ready <= '0;
      load_done  <= 1'b0;
      err        <= 1'b0;
      rk_valid   <= 1'b0;
      rk_data    <= '0;
      rk_last    <= 1'b0;
    end else begin
      ld_state  <= ld_state_nx_c;
      load_done <= ld_done_c;
      err       <= ld_err_c | rd_err_c;
      if (ld_accept_c) begin
        ld_slot               <= load_slot;
        ld_nr                 <= ld_len_nr_c;
        ld_idx                <= '0;
        slot_ready[load_slot] <= 1'b0;
      end
      if (ld_write_c) ld_idx <= ld_idx + IDX_W'(1);
      if (ld_done_c) slot_ready[ld_slot] <= 1'b1;

      rd_state  <= rd_state_nx_c;
      rd_slot_q <= rd_slot_c;
      rd_dir    <= rd_dir_c;
      rd_nr     <= rd_nr_c;
      rd_idx    <= rd_idx_nx_c;
      rk_valid  <= (rd_state_nx_c == RD_STREAM);
      if (rd_fetch_c) begin
        rk_data <= rd_word_c;
        rk_last <= rd_last_nx_c;
      end else if (rd_state_nx_c == RD_IDLE) begin
        rk_last <= 1'b0;
      end
    end
  end

  // Key storage and per-slot Nr survive reset
  always_ff @(posedge clk) begin
    if (ld_write_c) mem[ld_addr_c] <= load_rk;
    if (ld_accept_c) slot_nr[load_slot] <= ld_len_nr_c;
  end

  assign load_busy = (ld_state == LD_FILL);
  assign rd_busy   = (rd_state == RD_STREAM);

endmodule

// File: tb/tb_round_key_bank.sv
// tb_round_key_bank: scoreboard bench for round_key_bank; expected keys queued at rd_start, popped on handshake.
module tb_round_key_bank;
  localparam int unsigned NUM_SLOTS = 2;
  localparam int unsigned MAX_RK    = 15;
  localparam int unsigned RK_W      = 128;
  localparam int unsigned SLOT_W    = 1;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 load_start, load_rk_valid, rd_start, rd_decrypt, rk_ready;
  logic [SLOT_W-1:0]    load_slot, rd_slot;
  logic [1:0]           load_key_length;
  logic [RK_W-1:0]      load_rk, rk_data;
  logic                 load_busy, load_done, rk_valid, rk_last, rd_busy, err;
  logic [NUM_SLOTS-1:0] slot_ready;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [127:0] keys [2][15];
  logic [3:0]   pat = 4'b1001;
  logic         held_v = 1'b0;
  logic [127:0] held_d;
  logic         held_l;
  int           n_checks = 0;
  int           n_pass = 0;
  int           hs_count = 0;

  round_key_bank #(.NUM_SLOTS(NUM_SLOTS), .MAX_RK(MAX_RK), .RK_W(RK_W)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_slot(load_slot), .load_key_length(load_key_length),
    .load_rk_valid(load_rk_valid), .load_rk(load_rk),
    .load_busy(load_busy), .load_done(load_done),
    .rd_start(rd_start), .rd_slot(rd_slot), .rd_decrypt(rd_decrypt),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_last(rk_last),
    .rd_busy(rd_busy), .slot_ready(slot_ready), .err(err)
  );

  always #5 clk = ~clk;

`ifdef RKB_EQINV_EN
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] imc_model(input logic [127:0] s);
    logic [7:0]   m [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] r = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[127 - 32*c - 8*j -: 8], m[(j - row + 4) % 4]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    return r;
  endfunction
`endif

  // Scoreboard consumer: pop on every handshake, and hold-check every stalled offer
  always @(negedge clk) begin
    if (!rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        n_checks++;
        if (rk_valid !== 1'b1 || rk_data !== held_d || rk_last !== held_l)
          $display("FAIL stall_hold: valid %b data %h last %b, required 1 %h %b", rk_valid, rk_data, rk_last, held_d, held_l);
        else n_pass++;
      end
      if (rk_valid === 1'b1 && rk_ready === 1'b1) begin
        hs_count++;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: handshake with data %h but queue empty", rk_data);
        end else begin
          mon_e = sb.pop_front();
          if (rk_data !== mon_e.data || rk_last !== mon_e.last)
            $display("FAIL sb_key: got %h last %b, required %h last %b", rk_data, rk_last, mon_e.data, mon_e.last);
          else n_pass++;
        end
      end
      held_v = (rk_valid === 1'b1) && (rk_ready !== 1'b1);
      held_d = rk_data;
      held_l = rk_last;
    end
  end

  task automatic do_load(input int slot, input logic [1:0] len, input int n);
    @(posedge clk); #1;
    load_start = 1'b1; load_slot = SLOT_W'(slot); load_key_length = len;
    @(posedge clk); #1;
    load_start = 1'b0;
    n_checks++;
    if (load_busy !== 1'b1 || slot_ready[slot] !== 1'b0)
      $display("FAIL load_accept: busy %b ready %b, required 1 0", load_busy, slot_ready[slot]);
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      load_rk_valid = 1'b1; load_rk = keys[slot][i];
      @(posedge clk); #1;
      if (i == n - 2) begin
        n_checks++;
        if (load_done !== 1'b0 || load_busy !== 1'b1)
          $display("FAIL load_early: done %b busy %b, required 0 1", load_done, load_busy);
        else n_pass++;
      end
    end
    load_rk_valid = 1'b0;
    n_checks++;
    if (load_done !== 1'b1 || load_busy !== 1'b0 || slot_ready[slot] !== 1'b1)
      $display("FAIL load_done: done %b busy %b ready %b, required 1 0 1", load_done, load_busy, slot_ready[slot]);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (load_done !== 1'b0) $display("FAIL load_done_pulse: done %b, required 0", load_done);
    else n_pass++;
  endtask

  task automatic run_replay(input int slot, input logic dec, input int nr, input int mode);
    exp_t e;
    int   cyc;
    for (int k = 0; k <= nr; k++) begin
      int idx = dec ? nr - k : k;
      e.data = keys[slot][idx];
`ifdef RKB_EQINV_EN
      if (dec && idx != 0 && idx != nr) e.data = imc_model(e.data);
`endif
      e.last = (k == nr);
      sb.push_back(e);
    end
    hs_count = 0;
    @(posedge clk); #1;
    rd_start = 1'b1; rd_slot = SLOT_W'(slot); rd_decrypt = dec; rk_ready = 1'b0;
    @(posedge clk); #1;
    rd_start = 1'b0;
    n_checks++;
    if (rk_valid !== 1'b1 || rd_busy !== 1'b1)
      $display("FAIL replay_start: valid %b busy %b, required 1 1", rk_valid, rd_busy);
    else n_pass++;
    cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      rk_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
      @(posedge clk); #1;
      cyc++;
    end
    rk_ready = 1'b0;
    n_checks++;
    if (hs_count != nr + 1 || sb.size() != 0)
      $display("FAIL replay_count: handshakes %0d left %0d, required %0d 0", hs_count, sb.size(), nr + 1);
    else n_pass++;
    n_checks++;
    if (rk_valid !== 1'b0 || rd_busy !== 1'b0 || rk_last !== 1'b0)
      $display("FAIL replay_end: valid %b busy %b last %b, required 0 0 0", rk_valid, rd_busy, rk_last);
    else n_pass++;
    if (mode == 0) begin
      n_checks++;
      if (cyc != nr + 1) $display("FAIL replay_b2b: cycles %0d, required %0d", cyc, nr + 1);
      else n_pass++;
    end
    sb.delete();
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({load_busy, load_done, rk_valid, rk_last, rd_busy, err} !== 6'b0 || slot_ready !== 2'b00 || rk_data !== 128'h0)
      $display("FAIL reset_outputs: flags %b ready %b data %h, required all 0",
               {load_busy, load_done, rk_valid, rk_last, rd_busy, err}, slot_ready, rk_data);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_errors();
    @(posedge clk); #1;
    rd_start = 1'b1; rd_slot = 1'b1; rd_decrypt = 1'b0;
    @(posedge clk); #1;
    rd_start = 1'b0;
    n_checks++;
    if (err !== 1'b1 || rd_busy !== 1'b0 || rk_valid !== 1'b0)
      $display("FAIL err_empty_slot: err %b busy %b valid %b, required 1 0 0", err, rd_busy, rk_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_pulse: err %b, required 0", err);
    else n_pass++;
    load_start = 1'b1; load_slot = 1'b0; load_key_length = 2'b11;
    @(posedge clk); #1;
    load_start = 1'b0;
    n_checks++;
    if (err !== 1'b1 || load_busy !== 1'b0 || slot_ready !== 2'b00)
      $display("FAIL err_bad_len: err %b busy %b ready %b, required 1 0 00", err, load_busy, slot_ready);
    else n_pass++;
  endtask

  task automatic test_load128();
    do_load(0, 2'b00, 11);
    n_checks++;
    if (slot_ready !== 2'b01) $display("FAIL load128_ready: ready %b, required 01", slot_ready);
    else n_pass++;
  endtask

  task automatic test_stall();
    fork
      run_replay(0, 1'b0, 10, 1);
      begin
        repeat (3) @(posedge clk);
        #1 rd_start = 1'b1; rd_slot = 1'b0; rd_decrypt = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        n_checks++;
        if (err !== 1'b1 || rd_busy !== 1'b1)
          $display("FAIL err_rd_busy: err %b busy %b, required 1 1", err, rd_busy);
        else n_pass++;
      end
    join
  endtask

  task automatic test_concurrent();
    fork
      run_replay(0, 1'b0, 10, 1);
      begin
        repeat (3) @(posedge clk);
        #1 load_start = 1'b1; load_slot = 1'b0; load_key_length = 2'b00;
        @(posedge clk); #1;
        load_start = 1'b0;
        n_checks++;
        if (err !== 1'b1 || load_busy !== 1'b0 || slot_ready[0] !== 1'b1)
          $display("FAIL err_load_streaming: err %b busy %b ready0 %b, required 1 0 1", err, load_busy, slot_ready[0]);
        else n_pass++;
        do_load(1, 2'b10, 15);
      end
    join
    n_checks++;
    if (slot_ready !== 2'b11) $display("FAIL concurrent_ready: ready %b, required 11", slot_ready);
    else n_pass++;
  endtask

  task automatic test_same_slot_and_reset();
    @(posedge clk); #1;
    load_start = 1'b1; load_slot = 1'b0; load_key_length = 2'b00;
    rd_start = 1'b1; rd_slot = 1'b0; rd_decrypt = 1'b0;
    @(posedge clk); #1;
    load_start = 1'b0;
    n_checks++;
    if (err !== 1'b1 || load_busy !== 1'b1 || rd_busy !== 1'b0 || slot_ready !== 2'b10)
      $display("FAIL same_slot: err %b lbusy %b rbusy %b ready %b, required 1 1 0 10", err, load_busy, rd_busy, slot_ready);
    else n_pass++;
    rd_slot = 1'b1; rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_rk_valid = 1'b1; load_rk = keys[0][i];
      @(posedge clk); #1;
      rd_start = 1'b0;
    end
    load_rk_valid = 1'b0;
    n_checks++;
    if (rd_busy !== 1'b1 || rk_valid !== 1'b1 || load_busy !== 1'b1)
      $display("FAIL pre_reset: rbusy %b valid %b lbusy %b, required 1 1 1", rd_busy, rk_valid, load_busy);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({load_busy, load_done, rk_valid, rk_last, rd_busy, err} !== 6'b0 || slot_ready !== 2'b00)
      $display("FAIL async_reset: flags %b ready %b, required 0 00",
               {load_busy, load_done, rk_valid, rk_last, rd_busy, err}, slot_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b1; rd_slot = 1'b0; rd_decrypt = 1'b0;
    @(posedge clk); #1;
    rd_start = 1'b0;
    n_checks++;
    if (err !== 1'b1 || rd_busy !== 1'b0 || rk_valid !== 1'b0)
      $display("FAIL err_after_reset: err %b busy %b valid %b, required 1 0 0", err, rd_busy, rk_valid);
    else n_pass++;
  endtask

  initial begin
    load_start = 1'b0; load_slot = '0; load_key_length = 2'b00; load_rk_valid = 1'b0; load_rk = '0;
    rd_start = 1'b0; rd_slot = '0; rd_decrypt = 1'b0; rk_ready = 1'b0;
    keys[0][0]  = 128'h000102030405060708090a0b0c0d0e0f;
    keys[0][1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    keys[0][2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    keys[0][3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    keys[0][4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    keys[0][5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    keys[0][6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    keys[0][7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    keys[0][8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    keys[0][9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    keys[0][10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    for (int i = 11; i < 15; i++) keys[0][i] = '0;
    for (int i = 0; i < 15; i++) keys[1][i] = {$urandom, $urandom, $urandom, $urandom};

    test_reset();
    test_errors();
    test_load128();
    run_replay(0, 1'b0, 10, 0);
    run_replay(0, 1'b1, 10, 0);
    test_stall();
    test_concurrent();
    run_replay(1, 1'b1, 14, 0);
    run_replay(1, 1'b0, 14, 1);
    test_same_slot_and_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
